// File: rtl/status_flag_ctrl_pkg.sv
// Shared definitions for the NZCV status-flag controller: condition-code
// encodings and the bit positions of each flag in the packed {Z,C,N,V} word.
package status_flag_ctrl_pkg;

    // Condition field encodings seen in ID.
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Flag bit indices within the packed status word {Z,C,N,V}.
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/status_flag_ctrl_cond_eval.sv
// Pure combinational condition evaluator: does condition i_cond hold for the
// packed flags i_flags? NV (1111) never holds.
module status_flag_ctrl_cond_eval
    import status_flag_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_z;
    logic w_c;
    logic w_n;
    logic w_v;

    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_n = i_flags[FLAG_N];
    assign w_v = i_flags[FLAG_V];

    // Decode the condition against the current flags.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = ~w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = ~w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = ~w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = ~w_v;
            COND_HI: o_pass = w_c & ~w_z;
            COND_LS: o_pass = ~w_c | w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = ~w_z & (w_n == w_v);
            COND_LE: o_pass = w_z | (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_flag_ctrl.sv
// NZCV status register owner. Tracks in-flight flag writers in a shift
// register, stalls conditional instructions in ID until their flags have
// committed, and reports cond_pass for the ID instruction.
// FLAG_LAT is the ID-issue to EXE-commit distance, legal range 1..4.
module status_flag_ctrl
    import status_flag_ctrl_pkg::*;
#(
    parameter int FLAG_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_cond,
    input  logic             id_s,
    input  logic             flush,
    input  logic             exe_we,
    input  logic [3:0]       exe_flags,
    output logic             stall,
    output logic             cond_pass,
    output logic [3:0]       status,
    output logic [2:0]       pending_cnt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             flag_err
);

    logic [FLAG_LAT-1:0] r_pending;
    logic [3:0]          r_status;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic                r_flag_err;

    logic [FLAG_LAT-1:0] w_pending_nxt;
    logic                w_stall;
    logic                w_issue;
    logic                w_set_issue;
    logic                w_retire;
    logic                w_err_evt;
    logic                w_eval_pass;
    logic [2:0]          w_pop;

    // Any older flag writer still in flight makes the flags stale for a
    // conditional; AL does not read flags. Reset forces stall low.
    assign w_stall = ~rst & id_valid & ~flush & (id_cond != COND_AL) & (|r_pending);

    // Reset also gates issue so cond_pass reads 0 while rst is held.
    assign w_issue     = ~rst & id_valid & ~w_stall & ~flush;
    assign w_set_issue = w_issue & id_s;

    // The top pending bit is the writer whose flags must arrive this cycle.
    assign w_retire = r_pending[FLAG_LAT-1];

    // Commit must line up with the retiring writer; inserting into a full
    // tracker would lose a writer.
    assign w_err_evt = (exe_we != w_retire) | (w_set_issue & (&r_pending));

    generate
        if (FLAG_LAT == 1) begin : g_lat1
            assign w_pending_nxt = w_set_issue;
        end else begin : g_latn
            assign w_pending_nxt = {r_pending[FLAG_LAT-2:0], w_set_issue};
        end
    endgenerate

    status_flag_ctrl_cond_eval u_cond_eval (
        .i_cond  (id_cond),
        .i_flags (r_status),
        .o_pass  (w_eval_pass)
    );

    // Population count of the pending tracker.
    always_comb begin
        w_pop = 3'd0;
        for (int i = 0; i < FLAG_LAT; i++) begin
            w_pop = w_pop + {2'b00, r_pending[i]};
        end
    end

    // Pending tracker shifts every cycle; stall does not freeze it because
    // writers already past ID keep moving down the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            // NOTE: non-blocking assignment so every register samples pre-edge values.
            r_pending <= w_pending_nxt;
        end
    end

    // Architectural flags update only on an EXE commit; no bypass to ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= 4'b0000;
        end else if (exe_we) begin
            r_status <= exe_flags;
        end
    end

    // Saturating stall-cycle performance counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag_err <= 1'b0;
        end else if (w_err_evt) begin
            r_flag_err <= 1'b1;
        end
    end

    assign stall        = w_stall;
    assign cond_pass    = w_issue & w_eval_pass;
    assign status       = r_status;
    assign pending_cnt  = w_pop;
    assign stall_cycles = r_stall_cycles;
    assign flag_err     = r_flag_err;

endmodule

// File: tb/tb_status_flag_ctrl.sv
// Self-checking bench for status_flag_ctrl: directed scenarios followed by a
// randomized run checked against an age-queue reference model.
module tb_status_flag_ctrl;

    localparam int FLAG_LAT = 2;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [3:0]       id_cond;
    logic             id_s;
    logic             flush;
    logic             exe_we;
    logic [3:0]       exe_flags;
    logic             stall;
    logic             cond_pass;
    logic [3:0]       status;
    logic [2:0]       pending_cnt;
    logic [CNT_W-1:0] stall_cycles;
    logic             flag_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: ages of in-flight flag writers (0 = just issued).
    int          m_ages[$];
    logic [3:0]  m_status;
    int          m_stall_cnt;
    logic        m_err;

    always #5 clk = ~clk;

    status_flag_ctrl #(
        .FLAG_LAT (FLAG_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_cond      (id_cond),
        .id_s         (id_s),
        .flush        (flush),
        .exe_we       (exe_we),
        .exe_flags    (exe_flags),
        .stall        (stall),
        .cond_pass    (cond_pass),
        .status       (status),
        .pending_cnt  (pending_cnt),
        .stall_cycles (stall_cycles),
        .flag_err     (flag_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic s,
                         input logic f, input logic we, input logic [3:0] fl);
        id_valid  = v;
        id_cond   = c;
        id_s      = s;
        flush     = f;
        exe_we    = we;
        exe_flags = fl;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b0000);
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    // Condition evaluation in the classic "base test, low bit inverts" form.
    function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, n, v, base;
        z  = f[3];
        cy = f[2];
        n  = f[1];
        v  = f[0];
        if (c == 4'b1111) return 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return c[0] ? ~base : base;
    endfunction

    function automatic logic m_retiring();
        foreach (m_ages[i]) if (m_ages[i] == FLAG_LAT - 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_ages.delete();
        m_status    = 4'b0000;
        m_stall_cnt = 0;
        m_err       = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000);
        rst = 1'b1;
        #12;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall); end
        checks++; if (cond_pass !== 1'b0) begin errors++; $display("FAIL rst_cond_pass got=%b exp=0", cond_pass); end
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL rst_status got=%b exp=0000", status); end
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL rst_pending_cnt got=%0d exp=0", pending_cnt); end
        checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL rst_stall_cycles got=%0d exp=0", stall_cycles); end
        checks++; if (flag_err !== 1'b0) begin errors++; $display("FAIL rst_flag_err got=%b exp=0", flag_err); end
        tick();
        rst = 1'b0;
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL eq_idle_stall got=%b exp=0", stall); end
        checks++; if (cond_pass !== 1'b0) begin errors++; $display("FAIL eq_idle_pass got=%b exp=0", cond_pass); end
        drive(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000);
        #1;
        checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL ne_idle_pass got=%b exp=1", cond_pass); end
        tick();
    endtask

    task automatic test_flag_setter();
        do_reset();
        drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b0000);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL set_al_stall got=%b exp=0", stall); end
        checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL set_al_pass got=%b exp=1", cond_pass); end
        tick();
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL set_eq_stall1 got=%b exp=1", stall); end
        checks++; if (pending_cnt !== 3'd1) begin errors++; $display("FAIL set_pcnt1 got=%0d exp=1", pending_cnt); end
        tick();
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1000);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL set_eq_stall2 got=%b exp=1", stall); end
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL set_no_bypass got=%b exp=0000", status); end
        tick();
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL set_eq_release got=%b exp=0", stall); end
        checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL set_eq_pass got=%b exp=1", cond_pass); end
        checks++; if (status !== 4'b1000) begin errors++; $display("FAIL set_status got=%b exp=1000", status); end
        checks++; if (stall_cycles !== 4'd2) begin errors++; $display("FAIL set_stall_cycles got=%0d exp=2", stall_cycles); end
        checks++; if (flag_err !== 1'b0) begin errors++; $display("FAIL set_flag_err got=%b exp=0", flag_err); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'b0000);
        #1;
        checks++; if (cond_pass !== 1'b0) begin errors++; $display("FAIL flush_pass got=%b exp=0", cond_pass); end
        tick();
        drive(1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 4'b0000);
        #1;
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL flush_pcnt got=%0d exp=0", pending_cnt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_gt_stall got=%b exp=0", stall); end
        checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL flush_gt_pass got=%b exp=1", cond_pass); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b0000);
        tick();
        tick();
        drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b1, 4'b0010);
        #1;
        checks++; if (pending_cnt !== 3'd2) begin errors++; $display("FAIL b2b_pcnt got=%0d exp=2", pending_cnt); end
        tick();
        drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b1, 4'b0001);
        #1;
        checks++; if (status !== 4'b0010) begin errors++; $display("FAIL b2b_status1 got=%b exp=0010", status); end
        tick();
        drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b0000);
        #1;
        checks++; if (status !== 4'b0001) begin errors++; $display("FAIL b2b_status2 got=%b exp=0001", status); end
        checks++; if (flag_err !== 1'b0) begin errors++; $display("FAIL b2b_flag_err got=%b exp=0", flag_err); end
        checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL b2b_pcnt_end got=%0d exp=0", pending_cnt); end
    endtask

    task automatic test_flag_err();
        drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b1, 4'b0000);
        tick();
        drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b0000);
        #1;
        checks++; if (flag_err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", flag_err); end
        tick();
        tick();
        checks++; if (flag_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", flag_err); end
        drive(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b0000);
        tick();
        drive(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL err_stall got=%b exp=1", stall); end
        tick();
        checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL err_stall_cycles got=%0d exp=1", stall_cycles); end
        rst = 1'b1;
        #1;
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL midrst_status got=%b exp=0000", status); end
        checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL midrst_stall_cycles got=%0d exp=0", stall_cycles); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got=%b exp=0", stall); end
        checks++; if (flag_err !== 1'b0) begin errors++; $display("FAIL midrst_flag_err got=%b exp=0", flag_err); end
        rst = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL postrst_stall got=%b exp=0", stall); end
        checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL postrst_ne_pass got=%b exp=1", cond_pass); end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        exp_cnt = 0;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) drive(1'b1, 4'b1110, 1'b1, 1'b0, (k >= 2), 4'b0000);
            else            drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
            #1;
            checks++;
            if (stall !== ((k % 2) == 1)) begin
                errors++; $display("FAIL sat_stall k=%0d got=%b exp=%b", k, stall, (k % 2) == 1);
            end
            checks++;
            if (stall_cycles !== exp_cnt[CNT_W-1:0]) begin
                errors++; $display("FAIL sat_count k=%0d got=%0d exp=%0d", k, stall_cycles, exp_cnt);
            end
            if ((k % 2) == 1 && exp_cnt < 15) exp_cnt++;
            tick();
        end
        checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_final got=%0d exp=15", stall_cycles); end
        checks++; if (flag_err !== 1'b0) begin errors++; $display("FAIL sat_flag_err got=%b exp=0", flag_err); end
    endtask

    task automatic test_random();
        logic       v, s, f, we, e_stall, e_issue, e_pass, err_evt;
        logic [3:0] c, fl;
        int         kept[$];
        do_reset();
        model_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                do_reset();
                model_reset();
            end
            v  = ($urandom_range(3) != 0);
            c  = ($urandom_range(3) == 0) ? 4'b1110 : 4'($urandom_range(15));
            s  = $urandom_range(1);
            f  = ($urandom_range(7) == 0);
            we = m_retiring();
            if (i > 450 && $urandom_range(63) == 0) we = ~we;
            fl = 4'($urandom_range(15));
            drive(v, c, s, f, we, fl);

            e_stall = v & ~f & (c != 4'b1110) & (m_ages.size() != 0);
            e_issue = v & ~e_stall & ~f;
            e_pass  = e_issue & ref_eval(c, m_status);
            err_evt = (we != m_retiring()) | (e_issue & s & (m_ages.size() == FLAG_LAT));
            #2;
            checks++; if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, stall, e_stall); end
            checks++; if (cond_pass !== e_pass) begin errors++; $display("FAIL rnd_pass i=%0d cond=%b got=%b exp=%b", i, c, cond_pass, e_pass); end
            checks++; if (status !== m_status) begin errors++; $display("FAIL rnd_status i=%0d got=%b exp=%b", i, status, m_status); end
            checks++; if (pending_cnt !== 3'(m_ages.size())) begin errors++; $display("FAIL rnd_pcnt i=%0d got=%0d exp=%0d", i, pending_cnt, m_ages.size()); end
            checks++; if (stall_cycles !== 4'(m_stall_cnt)) begin errors++; $display("FAIL rnd_stall_cycles i=%0d got=%0d exp=%0d", i, stall_cycles, m_stall_cnt); end
            checks++; if (flag_err !== m_err) begin errors++; $display("FAIL rnd_flag_err i=%0d got=%b exp=%b", i, flag_err, m_err); end

            @(posedge clk);
            if (we) m_status = fl;
            if (err_evt) m_err = 1'b1;
            if (e_stall && m_stall_cnt < (1 << CNT_W) - 1) m_stall_cnt++;
            kept.delete();
            foreach (m_ages[j]) if (m_ages[j] + 1 < FLAG_LAT) kept.push_back(m_ages[j] + 1);
            if (e_issue && s) kept.push_back(0);
            m_ages = kept;
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b0000);
        test_reset();
        test_flag_setter();
        test_flush();
        test_back_to_back();
        test_flag_err();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
